// File: rtl/ext_irq_gateway.sv
// External interrupt gateway: synchronises NUM_SRC asynchronous lines, latches
// level/edge events into pending bits, and drives a single registered interrupt
// request to the core. A valid/ready register port gives firmware enable,
// trigger selection and a claim/complete handshake.
module ext_irq_gateway #(
   parameter int unsigned NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0C00_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gw_i_valid,
   input  logic [31:0]        gw_i_addr,
   input  logic               gw_i_wr,
   input  logic               gw_i_rd,
   input  logic [31:0]        gw_i_wdata,
   output logic               gw_o_ready,
   output logic [31:0]        gw_o_rdata,
   input  logic [NUM_SRC-1:0] gw_i_irq_src,
   output logic               gw_o_external_interrupt
);

   localparam logic [7:0] OFF_PENDING = 8'h00;
   localparam logic [7:0] OFF_ENABLE  = 8'h04;
   localparam logic [7:0] OFF_TRIGGER = 8'h08;
   localparam logic [7:0] OFF_CLAIM   = 8'h0C;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } bus_state_e;

   bus_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] sync1_q, sync1_d;
   logic [NUM_SRC-1:0] sync2_q, sync2_d;
   logic [NUM_SRC-1:0] hist_q, hist_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] trigger_q, trigger_d;
   logic [NUM_SRC-1:0] in_service_q, in_service_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               irq_q, irq_d;

   logic [NUM_SRC-1:0] src_event;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] claim_sel;
   logic [NUM_SRC-1:0] complete_sel;
   logic [4:0]         claim_id;
   logic               do_claim;
   logic               do_complete;
   logic               in_win;
   logic [7:0]         offset;

   // Upper write-data bits have no register behind them.
   logic unused_wdata;
   assign unused_wdata = ^gw_i_wdata;

   assign in_win = (gw_i_addr[31:8] == BASE_ADDR[31:8]);
   assign offset = gw_i_addr[7:0];

   assign gw_o_ready              = (state_q == ST_RESP);
   assign gw_o_rdata              = rdata_q;
   assign gw_o_external_interrupt = irq_q;

   // Synchronizer chain, edge history and per-source event detection.
   always_comb begin
      sync1_d   = gw_i_irq_src;
      sync2_d   = sync1_q;
      hist_d    = sync2_q;
      src_event = (sync2_q & ~trigger_q) | (sync2_q & ~hist_q & trigger_q);
   end

   // Lowest-numbered pending and enabled source wins the claim.
   always_comb begin
      active    = pending_q & enable_q;
      claim_id  = '0;
      claim_sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            claim_id     = 5'(i + 1);
            claim_sel    = '0;
            claim_sel[i] = 1'b1;
         end
      end
   end

   // Complete only retires an ID that is currently in service.
   always_comb begin
      complete_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gw_i_wdata[4:0] == 5'(i + 1)) begin
            complete_sel[i] = in_service_q[i];
         end
      end
   end

   // Bus FSM plus register side effects, applied on the acceptance edge.
   always_comb begin
      state_d     = state_q;
      rdata_d     = '0;
      enable_d    = enable_q;
      trigger_d   = trigger_q;
      do_claim    = 1'b0;
      do_complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gw_i_valid) begin
               state_d = ST_RESP;
               if (in_win && gw_i_wr) begin
                  case (offset)
                     OFF_ENABLE:  enable_d    = gw_i_wdata[NUM_SRC-1:0];
                     OFF_TRIGGER: trigger_d   = gw_i_wdata[NUM_SRC-1:0];
                     OFF_CLAIM:   do_complete = 1'b1;
                     default: ;
                  endcase
               end else if (in_win && gw_i_rd) begin
                  case (offset)
                     OFF_PENDING: rdata_d = 32'(pending_q);
                     OFF_ENABLE:  rdata_d = 32'(enable_q);
                     OFF_TRIGGER: rdata_d = 32'(trigger_q);
                     OFF_CLAIM: begin
                        rdata_d  = 32'(claim_id);
                        do_claim = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending/in-service update: events are dropped while pending or in service,
   // and a claim in the same cycle as an event always wins.
   always_comb begin
      pending_d    = pending_q | (src_event & ~pending_q & ~in_service_q);
      in_service_d = in_service_q;
      if (do_claim) begin
         pending_d    = pending_d & ~claim_sel;
         in_service_d = in_service_d | claim_sel;
      end
      if (do_complete) begin
         in_service_d = in_service_d & ~complete_sel;
      end
      irq_d = |(pending_q & enable_q);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sync1_q      <= '0;
         sync2_q      <= '0;
         hist_q       <= '0;
         pending_q    <= '0;
         enable_q     <= '0;
         trigger_q    <= '0;
         in_service_q <= '0;
         rdata_q      <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         hist_q       <= hist_d;
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         trigger_q    <= trigger_d;
         in_service_q <= in_service_d;
         rdata_q      <= rdata_d;
         irq_q        <= irq_d;
      end
   end

endmodule

// File: tb/tb_ext_irq_gateway.sv
// Testbench for ext_irq_gateway: scoreboarded register reads plus direct
// checks of the interrupt output timing.
module tb_ext_irq_gateway;

   localparam int unsigned NUM_SRC   = 8;
   localparam logic [31:0] BASE      = 32'h0C00_0000;
   localparam logic [31:0] A_PENDING = BASE + 32'h00;
   localparam logic [31:0] A_ENABLE  = BASE + 32'h04;
   localparam logic [31:0] A_TRIGGER = BASE + 32'h08;
   localparam logic [31:0] A_CLAIM   = BASE + 32'h0C;

   logic               clk;
   logic               rst_n;
   logic               valid;
   logic [31:0]        addr;
   logic               wr;
   logic               rd;
   logic [31:0]        wdata;
   logic               ready;
   logic [31:0]        rdata;
   logic [NUM_SRC-1:0] src;
   logic               irq;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   ext_irq_gateway #(
      .NUM_SRC  (NUM_SRC),
      .BASE_ADDR(BASE)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .gw_i_valid             (valid),
      .gw_i_addr              (addr),
      .gw_i_wr                (wr),
      .gw_i_rd                (rd),
      .gw_i_wdata             (wdata),
      .gw_o_ready             (ready),
      .gw_o_rdata             (rdata),
      .gw_i_irq_src           (src),
      .gw_o_external_interrupt(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus transaction; the expected read data is queued at issue time and
   // compared against the response when ready appears.
   task automatic bus_xfer(input string tag, input logic [31:0] a, input logic w,
                           input logic r, input logic [31:0] d, input logic [31:0] exp_rdata);
      bit          got;
      logic [31:0] exp;
      @(negedge clk);
      valid = 1'b1;
      addr  = a;
      wr    = w;
      rd    = r;
      wdata = d;
      exp_q.push_back(exp_rdata);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1'b1;
      end
      valid = 1'b0;
      wr    = 1'b0;
      rd    = 1'b0;
      if (!got) begin
         check({tag, " timeout"}, 32'd0, 32'd1);
         void'(exp_q.pop_front());
      end else begin
         exp = exp_q.pop_front();
         check(tag, rdata, exp);
         @(negedge clk);
         check({tag, " ready once"}, 32'(ready), 32'd0);
      end
   endtask

   task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus_xfer(tag, a, 1'b0, 1'b1, 32'd0, exp);
   endtask

   task automatic wr_reg(input string tag, input logic [31:0] a, input logic [31:0] d);
      bus_xfer(tag, a, 1'b1, 1'b0, d, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      addr  = '0;
      wr    = 1'b0;
      rd    = 1'b0;
      wdata = '0;
      src   = '0;

      // Reset state
      #3;
      check("reset ready", 32'(ready), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      wait_cycles(2);
      rst_n = 1'b1;
      rd_reg("rst enable", A_ENABLE, 32'd0);
      rd_reg("rst claim", A_CLAIM, 32'd0);

      // Level source 3: four-edge latency, claim, re-pend after complete
      wr_reg("wr enable", A_ENABLE, 32'h04);
      wr_reg("wr trigger", A_TRIGGER, 32'h00);
      src = 8'h04;
      wait_cycles(3);
      check("lvl irq edge3", 32'(irq), 32'd0);
      wait_cycles(1);
      check("lvl irq edge4", 32'(irq), 32'd1);
      rd_reg("claim 3", A_CLAIM, 32'd3);
      check("irq after claim", 32'(irq), 32'd0);
      rd_reg("pending after claim", A_PENDING, 32'd0);
      wr_reg("complete 3", A_CLAIM, 32'd3);
      check("irq 1 after complete", 32'(irq), 32'd0);
      wait_cycles(1);
      check("irq reassert", 32'(irq), 32'd1);
      src = 8'h00;
      rd_reg("claim 3 again", A_CLAIM, 32'd3);
      wr_reg("complete 3 again", A_CLAIM, 32'd3);
      wait_cycles(3);
      rd_reg("pending clear", A_PENDING, 32'd0);
      check("irq idle", 32'(irq), 32'd0);

      // Edge source 1: two pulses collapse into one pending
      wr_reg("wr trigger edge", A_TRIGGER, 32'h01);
      wr_reg("wr enable 1", A_ENABLE, 32'h01);
      src = 8'h01;
      wait_cycles(3);
      src = 8'h00;
      wait_cycles(3);
      src = 8'h01;
      wait_cycles(3);
      src = 8'h00;
      wait_cycles(5);
      check("edge irq", 32'(irq), 32'd1);
      rd_reg("edge pending", A_PENDING, 32'h01);
      rd_reg("claim 1", A_CLAIM, 32'd1);
      wr_reg("complete 1", A_CLAIM, 32'd1);
      wait_cycles(6);
      check("no second irq", 32'(irq), 32'd0);
      rd_reg("claim none", A_CLAIM, 32'd0);
      rd_reg("edge pending clear", A_PENDING, 32'd0);

      // Priority among sources 2 and 6
      wr_reg("wr trigger lvl", A_TRIGGER, 32'h00);
      wr_reg("wr enable 22", A_ENABLE, 32'h22);
      rd_reg("rd enable 22", A_ENABLE, 32'h22);
      src = 8'h22;
      wait_cycles(5);
      src = 8'h00;
      wait_cycles(4);
      rd_reg("claim 2", A_CLAIM, 32'd2);
      rd_reg("claim 6", A_CLAIM, 32'd6);
      rd_reg("claim 0", A_CLAIM, 32'd0);

      // Illegal and stale completes leave in-service untouched
      wr_reg("complete 6", A_CLAIM, 32'd6);
      wr_reg("complete 9", A_CLAIM, 32'd9);
      wr_reg("complete 6 stale", A_CLAIM, 32'd6);
      src = 8'h22;
      wait_cycles(5);
      rd_reg("only 6 re-pends", A_PENDING, 32'h20);
      wr_reg("complete 2", A_CLAIM, 32'd2);
      wait_cycles(4);
      rd_reg("both pending", A_PENDING, 32'h22);
      check("irq both", 32'(irq), 32'd1);
      wr_reg("enable off", A_ENABLE, 32'h00);
      check("irq after disable", 32'(irq), 32'd0);
      src = 8'h00;

      // Decode corners
      wr_reg("wr unmapped 0x40", BASE + 32'h40, 32'hFFFF_FFFF);
      rd_reg("rd out of window", 32'h1000_0004, 32'd0);
      wr_reg("wr enable 22b", A_ENABLE, 32'h22);
      wr_reg("wr out of window", 32'h0C00_0104, 32'hFF);
      rd_reg("enable unchanged", A_ENABLE, 32'h22);
      wr_reg("wr trigger wide", A_TRIGGER, 32'hFFFF_FF01);
      rd_reg("trigger masked", A_TRIGGER, 32'h01);
      bus_xfer("wr+rd pending", A_PENDING, 1'b1, 1'b1, 32'd0, 32'd0);
      bus_xfer("no op", A_PENDING, 1'b0, 1'b0, 32'd0, 32'd0);
      wait_cycles(2);
      check("irq before reset", 32'(irq), 32'd1);

      // Reset while the response is being presented
      @(negedge clk);
      valid = 1'b1;
      addr  = A_PENDING;
      rd    = 1'b1;
      @(negedge clk);
      check("resp before reset", 32'(ready), 32'd1);
      valid = 1'b0;
      rd    = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("ready on reset", 32'(ready), 32'd0);
      check("rdata on reset", rdata, 32'd0);
      check("irq on reset", 32'(irq), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_reg("enable after reset", A_ENABLE, 32'd0);
      rd_reg("pending after reset", A_PENDING, 32'd0);
      rd_reg("trigger after reset", A_TRIGGER, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ext_irq_gateway.md
Name: ext_irq_gateway

Overview:
- Memory-mapped external-interrupt gateway. It collects NUM_SRC asynchronous interrupt lines and drives the single-bit external_interrupt input of the core top level.
- It is a bus responder on the core's valid/ready register-access interface: the same request signalling the execution unit uses toward the interrupt agent.
- Provides per-source enable, edge/level trigger selection, and a claim/complete handshake so firmware can identify and retire the interrupting source.

Parameters:
- NUM_SRC, 8, number of interrupt sources (legal 1..31); source IDs are 1..NUM_SRC.
- BASE_ADDR, 32'h0C00_0000, register window base; decode is addr[31:8] == BASE_ADDR[31:8].

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- gw_i_valid  in  1  request valid; held high by the initiator until gw_o_ready
- gw_i_addr  in  32  byte address
- gw_i_wr  in  1  write request
- gw_i_rd  in  1  read request
- gw_i_wdata  in  32  write data
- gw_o_ready  out  1  one-cycle response strobe
- gw_o_rdata  out  32  read data, valid while gw_o_ready=1
- gw_i_irq_src  in  NUM_SRC  asynchronous interrupt sources, bit i-1 = ID i
- gw_o_external_interrupt  out  1  registered interrupt request to the core

Behaviour:
Reset:
- All registers clear: pending, enable, trigger, in_service, synchronizers, edge history, bus FSM → IDLE.
- gw_o_ready=0, gw_o_rdata=0, gw_o_external_interrupt=0.
- Reset mid-transaction aborts it with no response; the initiator reissues the request.

Source path:
- 2-flop synchronizer per source, then a one-flop history register for edge detection.
- Event for source i:
  - TRIGGER[i]=0 (level): synced level high.
  - TRIGGER[i]=1 (edge): synced rise, 0→1.
- pending[i] sets on an event only when pending[i]=0 and in_service[i]=0; otherwise the event is dropped.
- Output rule: gw_o_external_interrupt <= |(pending & enable), registered.
- Latency: a source first sampled high at edge 1 asserts the output at edge 4.

Register map (offset = addr[7:0]):
- 0x00 PENDING: read-only; writes ignored.
- 0x04 ENABLE: read/write, bits [NUM_SRC-1:0]; upper bits read 0.
- 0x08 TRIGGER: read/write, same width rule as ENABLE.
- 0x0C CLAIM/COMPLETE:
  - Read returns the lowest ID with pending & enable set, or 0 if none.
  - In the same cycle the read clears that pending bit and sets in_service.
  - Write: wdata[4:0] = ID; if 1<=ID<=NUM_SRC and in_service[ID-1]=1, in_service is cleared; otherwise the write is ignored.
- Other offsets in the window, or an address outside the window: read 0, write ignored, still acknowledged.

Bus FSM:
- IDLE: on gw_i_valid=1, accept the request. Perform the write or read side effect on this edge, capture rdata, go to RESP.
- RESP: gw_o_ready=1 for exactly one cycle, rdata presented, return to IDLE. gw_i_valid is ignored in RESP.
- Throughput: one transaction per 2 cycles; response latency is 1 cycle after acceptance.
- gw_i_wr and gw_i_rd both high: treated as a write, and rdata=0.
- Valid with neither wr nor rd: acknowledged with no effect, rdata=0.

Simultaneous events:
- Claim of ID i and a new event on i in the same cycle: the claim wins, pending[i]=0 and in_service[i]=1, and the event is dropped.
- Complete of ID i and an event on i in the same cycle: in_service clears and the event is dropped; a level source re-pends on the next cycle.
- ENABLE write clearing the only active source: gw_o_external_interrupt deasserts on the edge after the write is accepted.

Test Plan:
- Reset → all outputs 0; read ENABLE returns 0; read CLAIM returns 0.
- Write ENABLE=0x04, TRIGGER=0; raise src[2] → gw_o_external_interrupt=1 on the 4th edge; read CLAIM=3; output drops the next cycle; PENDING reads 0.
- Level src[2] held high, then write CLAIM=3 → pending re-sets and the output reasserts 3 cycles after the complete.
- TRIGGER=0x01, ENABLE=0x01; pulse src[0] high for 3 cycles twice before claiming → only one pending; CLAIM=1; complete; no second interrupt.
- src[1] and src[5] both pending and enabled → CLAIM=2, then CLAIM=6, then CLAIM=0.
- Write CLAIM=9 (NUM_SRC=8) or an ID not in service → no state change; write to 0x40 → ready still pulses once; out-of-window read → rdata=0.
- Assert rst_n=0 during RESP → gw_o_ready=0 immediately, all state cleared.
